// File: rtl/alu_bitserial_seq_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM states,
// slice control bundle and the opcode decode helpers.
package alu_bitserial_seq_pkg;

  localparam logic [2:0] ALU_OP_AND  = 3'b000;
  localparam logic [2:0] ALU_OP_OR   = 3'b001;
  localparam logic [2:0] ALU_OP_ADD  = 3'b010;
  localparam logic [2:0] ALU_OP_ILL  = 3'b011;
  localparam logic [2:0] ALU_OP_NOR  = 3'b100;
  localparam logic [2:0] ALU_OP_NAND = 3'b101;
  localparam logic [2:0] ALU_OP_SUB  = 3'b110;
  localparam logic [2:0] ALU_OP_SLT  = 3'b111;

  localparam logic [1:0] SL_AND  = 2'b00;
  localparam logic [1:0] SL_OR   = 2'b01;
  localparam logic [1:0] SL_SUM  = 2'b10;
  localparam logic [1:0] SL_LESS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_LOGIC = 2'd0,
    K_ARITH = 2'd1,
    K_SLT   = 2'd2
  } kind_e;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] op;
    logic       cin0;
  } ctrl_t;

  function automatic ctrl_t alu_decode(
    input logic [2:0] alu_op
  );
    ctrl_t c;
    c = '{1'b0, 1'b0, SL_SUM, 1'b0};
    unique case (1'b1)
      (alu_op == ALU_OP_AND):
        c = '{1'b0, 1'b0, SL_AND, 1'b0};
      (alu_op == ALU_OP_OR):
        c = '{1'b0, 1'b0, SL_OR, 1'b0};
      (alu_op == ALU_OP_ADD),
      (alu_op == ALU_OP_ILL):
        c = '{1'b0, 1'b0, SL_SUM, 1'b0};
      (alu_op == ALU_OP_NOR):
        c = '{1'b1, 1'b1, SL_AND, 1'b0};
      (alu_op == ALU_OP_NAND):
        c = '{1'b1, 1'b1, SL_OR, 1'b0};
      (alu_op == ALU_OP_SUB),
      (alu_op == ALU_OP_SLT):
        c = '{1'b0, 1'b1, SL_SUM, 1'b1};
      default:
        c = '{1'b0, 1'b0, SL_SUM, 1'b0};
    endcase
    return c;
  endfunction

  function automatic kind_e op_kind(
    input logic [2:0] alu_op
  );
    kind_e k;
    k = K_LOGIC;
    unique case (1'b1)
      (alu_op == ALU_OP_ADD),
      (alu_op == ALU_OP_ILL),
      (alu_op == ALU_OP_SUB):
        k = K_ARITH;
      (alu_op == ALU_OP_SLT):
        k = K_SLT;
      default:
        k = K_LOGIC;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_bitserial_seq_alu_1bit.sv
// One-bit ALU slice: optional operand inversion, AND/OR/SUM/LESS mux.
// Ports: a,b,ainv,binv,cin,less,op[1:0] in; r,cout,set,overflow out.
module ALU_1bit
  import alu_bitserial_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       ainv,
  input  logic       binv,
  input  logic       cin,
  input  logic       less,
  input  logic [1:0] op,
  output logic       r,
  output logic       cout,
  output logic       set,
  output logic       overflow
);

  logic aa;
  logic bb;
  logic sum;

  always_comb begin
    aa       = a ^ ainv;
    bb       = b ^ binv;
    sum      = aa ^ bb ^ cin;
    cout     = (aa & bb) | (cin & (aa ^ bb));
    set      = sum;
    // Meaningful only on the MSB: carry-in vs carry-out disagree.
    overflow = cin ^ cout;
    r        = 1'b0;
    unique case (op)
      SL_AND:  r = aa & bb;
      SL_OR:   r = aa | bb;
      SL_SUM:  r = sum;
      SL_LESS: r = less;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial execute unit: one ALU_1bit slice, LSB-first, carry flop.
// Ports: clk,rst; in_valid/in_ready,alu_op,a,b; out_valid/out_ready,result,zero,carry,overflow.
module alu_bitserial_seq
  import alu_bitserial_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             vld_q, vld_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             s_r;
  logic             s_cout;
  logic             s_set;
  logic             s_ovf;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] fin;

  ALU_1bit u_slice (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .ainv     (ctrl_q.ainv),
    .binv     (ctrl_q.binv),
    .cin      (cy_q),
    .less     (1'b0),
    .op       (ctrl_q.op),
    .r        (s_r),
    .cout     (s_cout),
    .set      (s_set),
    .overflow (s_ovf)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    ctrl_d  = ctrl_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    vld_d   = vld_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    acc_nx  = {s_r, acc_q[WIDTH-1:1]};
    // SLT: sign of (a-b) corrected by overflow gives the signed compare.
    fin     = (kind_q == K_SLT)
            ? {{(WIDTH-1){1'b0}}, s_set ^ s_ovf}
            : acc_nx;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          ctrl_d  = alu_decode(alu_op);
          kind_d  = op_kind(alu_op);
          cy_d    = ctrl_d.cin0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cy_d   = s_cout;
        acc_d  = acc_nx;
        if (cnt_q == CNT_LAST) begin
          res_d   = fin;
          zero_d  = (fin == '0);
          carry_d = (kind_q == K_ARITH) & s_cout;
          ovf_d   = (kind_q == K_ARITH) & s_ovf;
          vld_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_LOGIC;
      ctrl_q  <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ctrl_q  <= ctrl_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = vld_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq (WIDTH=32): directed
// cases plus random ops against an arithmetic reference model.
module tb_alu_bitserial_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the opcode table.
  task automatic model(input  logic [2:0]   op,
                       input  logic [W-1:0] a,
                       input  logic [W-1:0] b,
                       output logic [W-1:0] r,
                       output logic         c,
                       output logic         v);
    logic [W:0] s;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = ~(a | b);
      3'b101: r = ~(a & b);
      3'b010, 3'b011: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      default: r = ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    alu_op   = op;
    a_i      = a;
    b_i      = b;
    tick();
    in_valid = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    alu_op   = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_out(input string tag,
                           input logic [2:0] op,
                           input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    logic         v;
    model(op, a, b, r, c, v);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, result, r);
    chk({tag, "_zero"}, zero, (r == '0));
    chk({tag, "_carry"}, carry, c);
    chk({tag, "_ovf"}, overflow, v);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask

  task automatic full_op(input string tag,
                         input logic [2:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, W);
    check_out(tag, op, a, b);
    release_out();
  endtask

  initial begin
    int           lat;
    int           seen;
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] hold_r;
    logic         hold_z;
    logic         hold_c;
    logic         hold_v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = 3'b000;
    a_i       = '0;
    b_i       = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);

    full_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    full_op("sub_eq", 3'b110, 32'd5, 32'd5);
    full_op("sub_neg", 3'b110, 32'd0, 32'd1);
    full_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1);
    full_op("slt_ovf", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
    full_op("slt_eq", 3'b111, 32'd3, 32'd3);
    full_op("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    full_op("or", 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    full_op("nor", 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    full_op("nand", 3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00);
    full_op("ill_add", 3'b011, 32'hFFFF_FFFF, 32'd1);

    // Backpressure: DONE held, new operands offered and ignored.
    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_valid(lat);
    chk("bp_latency", lat, W);
    check_out("bp", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    hold_r = result;
    hold_z = zero;
    hold_c = carry;
    hold_v = overflow;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      alu_op   = 3'b000;
      a_i      = $urandom;
      b_i      = $urandom;
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_result", result, 32'h8000_0000);
      chk("bp_hold_flags", {zero, carry, overflow},
          {hold_z, hold_c, hold_v});
    end
    chk("bp_hold_r_cmp", result, hold_r);
    in_valid = 1'b0;
    release_out();
    tick();
    chk("bp_not_taken_valid", out_valid, 0);
    chk("bp_not_taken_ready", in_ready, 1);
    full_op("bp_next", 3'b000, 32'h1234_5678, 32'h0F0F_0F0F);

    // Reset in the middle of an ADD at cnt=10.
    issue(3'b010, 32'hDEAD_BEEF, 32'h1111_1111);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    chk("mid_rst_no_stale", seen, 0);
    full_op("post_rst_add", 3'b010, 32'd2, 32'd3);

    // Reset beats a simultaneous accept.
    rst      = 1'b1;
    in_valid = 1'b1;
    alu_op   = 3'b010;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_wins_ready", in_ready, 1);

    // Randomized ops with random consumer delay.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ((n % 8) == 0) rb = ra;
      if ((n % 8) == 1) ra = 32'h8000_0000;
      issue(rop, ra, rb);
      wait_valid(lat);
      chk("rnd_latency", lat, W);
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'b0;
        tick();
      end
      check_out("rnd", rop, ra, rb);
      release_out();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
